dmi_host_master: RTL and testbench
==================================

// Module: dmi_host_master
// PURPOSE
//  Host-side DMI initiator: turns simple read/write commands (from a UART/bench debug bridge) into
//  DMI request/response transactions toward dm_csrs. Drop-in replacement for the JTAG DTM on the
//  dmi_req/dmi_resp ports of the debug module. Retries BUSY responses and reports the final status.
// PARAMETERS
//  MaxRetries    4     BUSY re-issues allowed per command before status BUSY is returned (0..15)
//  RetryGap      8     idle cycles between a BUSY response and the re-issue (>=1)
//  TimeoutCycles 1024  cycles waited in REQ or WAIT before status TIMEOUT (DMI_TIMEOUT_EN only)
// PORTS
//  clk_i           in   1   system clock
//  rst_i           in   1   synchronous reset, active-high
//  cmd_valid_i     in   1   host command valid
//  cmd_ready_o     out  1   block accepts command (high only in IDLE)
//  cmd_we_i        in   1   1 = DMI write, 0 = DMI read
//  cmd_addr_i      in   7   DMI register address
//  cmd_wdata_i     in   32  write data (ignored on reads)
//  clr_i           in   1   host request to pulse dmi_rst_no (honoured in IDLE only)
//  rsp_valid_o     out  1   result valid
//  rsp_ready_i     in   1   host consumes result
//  rsp_data_o      out  32  read data (last DMI response data; 0 on write)
//  rsp_status_o    out  2   0 OK, 1 TIMEOUT, 2 FAILED, 3 BUSY (retries exhausted)
//  dmi_rst_no      out  1   DMI reset to dm_csrs, active-low
//  dmi_req_o       out  41  {addr[40:34], data[33:2], op[1:0]}; op 1 = read, 2 = write
//  dmi_req_valid_o out  1   request valid
//  dmi_req_ready_i in   1   dm_csrs accepts request
//  dmi_resp_i      in   34  {data[33:2], resp[1:0]}; resp 0 OK, 2 FAILED, 3 BUSY
//  dmi_resp_valid_i in  1   response valid
//  dmi_resp_ready_o out 1   high only in WAIT
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready_o=1, rsp_valid_o=0, dmi_req_valid_o=0, dmi_req_o=0,
//   dmi_resp_ready_o=0, rsp_data_o=0, rsp_status_o=0, dmi_rst_no=1; counters 0. rst_i mid-
//   transaction aborts it silently: no rsp_valid_o, and an in-flight DMI response is discarded.
//  FSM IDLE->REQ->WAIT->(GAP->REQ)*->DONE->IDLE:
//   IDLE: cmd_valid_i&cmd_ready_o latches we/addr/wdata; retry count=0; next REQ.
//    clr_i in IDLE (no command that cycle): dmi_rst_no=0 for exactly 1 cycle; stay IDLE.
//    clr_i together with cmd_valid_i: command wins, clr_i ignored.
//   REQ: dmi_req_valid_o=1, payload stable until dmi_req_valid_o&dmi_req_ready_i; then WAIT.
//   WAIT: dmi_resp_ready_o=1; on dmi_resp_valid_i:
//    resp 0 -> status OK, rsp_data_o = resp data (read) or 0 (write); DONE.
//    resp 2, or the reserved code 1 -> status FAILED, rsp_data_o = resp data; DONE.
//    resp 3 and retries<MaxRetries -> retries++, GAP; else status BUSY; DONE.
//   GAP: count RetryGap cycles, then REQ with identical payload.
//   DONE: rsp_valid_o=1, held with stable data until rsp_ready_i; next IDLE; cmd_ready_o=1
//    the following cycle (no command/response overlap, one outstanding transaction).
//  Latency, zero-wait responder (ready=1, response 1 cycle after accept):
//   accept->REQ 1, REQ->WAIT 1, resp->DONE 1; rsp_valid_o 4 cycles after command accept.
//  Retry counter is 4 bits and saturates at MaxRetries; total issues = MaxRetries+1.
// CONFIGURATION
//  DMI_TIMEOUT_EN defined: a cycle counter is cleared on each REQ/WAIT entry. When it reaches
//   TimeoutCycles-1 in REQ or WAIT: drop dmi_req_valid_o, status TIMEOUT, rsp_data_o=0, DONE.
//   A late response arriving after the timeout is accepted while in IDLE (dmi_resp_ready_o=1)
//   and discarded.
//  DMI_TIMEOUT_EN undefined: no counter; REQ/WAIT wait forever; status 1 is never produced.
// STRUCTURE
//  Shared header dm_defines.vh (include file used as a package): DMI op codes (NOP/READ/WRITE),
//   resp codes, rsp_status codes, field offsets of dmi_req/dmi_resp, FSM state encodings.
//  One sub-module dmi_gap_timer: loadable down-counter shared by GAP and timeout counting
//   (load, enable, done). Everything else stays in dmi_host_master.
// TESTING
//  1 read addr 0x11, responder ready=1, resp {0xDEADBEEF,0} -> rsp OK, data 0xDEADBEEF, 4 cycles.
//  2 write addr 0x04 data 0x12345678, dmi_req_ready_i low 3 cycles -> dmi_req_o stable
//    {0x04,0x12345678,2} through the stall; rsp OK, data 0.
//  3 responder BUSY x2 then OK -> 3 request handshakes, RetryGap idle cycles between them; rsp OK.
//  4 responder always BUSY, MaxRetries=4 -> exactly 5 requests; rsp status 3.
//  5 DMI_TIMEOUT_EN, TimeoutCycles=16, no response -> status 1 at cycle 16 of WAIT; a late
//    response is discarded; next command completes OK.
//  6 clr_i in IDLE -> dmi_rst_no low 1 cycle; rst_i asserted in WAIT -> IDLE, no rsp_valid_o.

Source files
------------

// File: rtl/dmi_host_master_pkg.sv
// Shared DMI encodings, payload layouts and FSM states for the host-side DMI initiator.
package dmi_host_master_pkg;

    localparam int unsigned AddrW   = 7;
    localparam int unsigned DataW   = 32;
    localparam int unsigned OpW     = 2;
    localparam int unsigned CodeW   = 2;
    localparam int unsigned StatusW = 2;
    localparam int unsigned RetryW  = 4;
    localparam int unsigned ReqW    = AddrW + DataW + OpW;
    localparam int unsigned RespW   = DataW + CodeW;

    typedef enum logic [OpW-1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } dmi_op_e;

    typedef enum logic [CodeW-1:0] {
        RESP_OK     = 2'd0,
        RESP_RSVD   = 2'd1,
        RESP_FAILED = 2'd2,
        RESP_BUSY   = 2'd3
    } dmi_code_e;

    typedef enum logic [StatusW-1:0] {
        STATUS_OK      = 2'd0,
        STATUS_TIMEOUT = 2'd1,
        STATUS_FAILED  = 2'd2,
        STATUS_BUSY    = 2'd3
    } rsp_status_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef struct packed {
        logic [AddrW-1:0] addr;
        logic [DataW-1:0] data;
        dmi_op_e          op;
    } dmi_req_t;

    typedef struct packed {
        logic [DataW-1:0] data;
        dmi_code_e        code;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_host_master_gap_timer.sv
// Loadable down-counter shared by retry-gap and request/response timeout counting.
module dmi_host_master_gap_timer #(
    parameter int unsigned W = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done_c
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && !done_c) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done_c = (cnt_q == '0);

endmodule

// File: rtl/dmi_host_master.sv
// Host-side DMI initiator: issues read/write commands to dm_csrs, retries BUSY, reports status.
// Optional feature macro: DMI_TIMEOUT_EN (REQ/WAIT timeout with TIMEOUT status).
module dmi_host_master
    import dmi_host_master_pkg::*;
#(
    parameter int unsigned MaxRetries    = 4,
    parameter int unsigned RetryGap      = 8,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_we_i,
    input  logic [AddrW-1:0]   cmd_addr_i,
    input  logic [DataW-1:0]   cmd_wdata_i,
    input  logic               clr_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [DataW-1:0]   rsp_data_o,
    output logic [StatusW-1:0] rsp_status_o,
    output logic               dmi_rst_no,
    output logic [ReqW-1:0]    dmi_req_o,
    output logic               dmi_req_valid_o,
    input  logic               dmi_req_ready_i,
    input  logic [RespW-1:0]   dmi_resp_i,
    input  logic               dmi_resp_valid_i,
    output logic               dmi_resp_ready_o
);

    localparam int unsigned TimerMax = (RetryGap > TimeoutCycles) ? RetryGap : TimeoutCycles;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);

    state_e              state_q, state_d;
    dmi_req_t            req_q, req_d;
    logic [RetryW-1:0]   retry_q, retry_d;
    logic [DataW-1:0]    data_q, data_d;
    rsp_status_e         status_q, status_d;
    logic                rst_n_d;
    logic                tmr_load, tmr_en, tmr_done, timeout_hit;
    logic [TimerW-1:0]   tmr_val;
    dmi_resp_t           resp;

    assign resp         = dmi_resp_t'(dmi_resp_i);
    assign dmi_req_o    = req_q;
    assign rsp_data_o   = data_q;
    assign rsp_status_o = status_q;

    dmi_host_master_gap_timer #(.W(TimerW)) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .done_c   (tmr_done)
    );

    // Next-state, payload/status capture and timer control
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        retry_d     = retry_q;
        data_d      = data_q;
        status_d    = status_q;
        rst_n_d     = 1'b1;
`ifdef DMI_TIMEOUT_EN
        timeout_hit = tmr_done;
`else
        timeout_hit = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    req_d.addr = cmd_addr_i;
                    req_d.data = cmd_wdata_i;
                    req_d.op   = cmd_we_i ? OP_WRITE : OP_READ;
                    retry_d    = '0;
                    state_d    = ST_REQ;
                end else if (clr_i) begin
                    rst_n_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (dmi_req_valid_o && dmi_req_ready_i) begin
                    state_d = ST_WAIT;
                end else if (timeout_hit) begin
                    status_d = STATUS_TIMEOUT;
                    data_d   = '0;
                    state_d  = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (dmi_resp_valid_i && dmi_resp_ready_o) begin
                    case (resp.code)
                        RESP_OK: begin
                            status_d = STATUS_OK;
                            data_d   = (req_q.op == OP_WRITE) ? '0 : resp.data;
                            state_d  = ST_DONE;
                        end
                        RESP_BUSY: begin
                            if (retry_q < RetryW'(MaxRetries)) begin
                                retry_d = retry_q + RetryW'(1);
                                state_d = ST_GAP;
                            end else begin
                                status_d = STATUS_BUSY;
                                data_d   = resp.data;
                                state_d  = ST_DONE;
                            end
                        end
                        default: begin
                            status_d = STATUS_FAILED;
                            data_d   = resp.data;
                            state_d  = ST_DONE;
                        end
                    endcase
                end else if (timeout_hit) begin
                    status_d = STATUS_TIMEOUT;
                    data_d   = '0;
                    state_d  = ST_DONE;
                end
            end
            ST_GAP: begin
                if (tmr_done) begin
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The timer restarts on every entry into a counted state
`ifdef DMI_TIMEOUT_EN
        tmr_load = (state_d != state_q) && (state_d inside {ST_GAP, ST_REQ, ST_WAIT});
`else
        tmr_load = (state_d != state_q) && (state_d == ST_GAP);
`endif
        tmr_val = (state_d == ST_GAP) ? TimerW'(RetryGap - 1) : TimerW'(TimeoutCycles - 1);
        tmr_en  = !tmr_load;
    end

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= ST_IDLE;
            req_q            <= '0;
            retry_q          <= '0;
            data_q           <= '0;
            status_q         <= STATUS_OK;
            cmd_ready_o      <= 1'b1;
            rsp_valid_o      <= 1'b0;
            dmi_rst_no       <= 1'b1;
            dmi_req_valid_o  <= 1'b0;
            dmi_resp_ready_o <= 1'b0;
        end else begin
            state_q          <= state_d;
            req_q            <= req_d;
            retry_q          <= retry_d;
            data_q           <= data_d;
            status_q         <= status_d;
            cmd_ready_o      <= (state_d == ST_IDLE);
            rsp_valid_o      <= (state_d == ST_DONE);
            dmi_rst_no       <= rst_n_d;
            dmi_req_valid_o  <= (state_d == ST_REQ);
`ifdef DMI_TIMEOUT_EN
            // Late responses after a timeout are drained while idle
            dmi_resp_ready_o <= (state_d == ST_WAIT) || (state_d == ST_IDLE);
`else
            dmi_resp_ready_o <= (state_d == ST_WAIT);
`endif
        end
    end

endmodule

// File: tb/tb_dmi_host_master.sv
// Self-checking bench for dmi_host_master: scripted DMI responder plus expected-result queue.
module tb_dmi_host_master;

    localparam int unsigned MaxRetries    = 4;
    localparam int unsigned RetryGap      = 8;
    localparam int unsigned TimeoutCycles = 16;
    localparam logic [31:0] BusyData      = 32'h0BAD_0B05;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [6:0]  cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic        clr_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic [1:0]  rsp_status_o;
    logic        dmi_rst_no;
    logic [40:0] dmi_req_o;
    logic        dmi_req_valid_o, dmi_req_ready_i;
    logic [33:0] dmi_resp_i;
    logic        dmi_resp_valid_i, dmi_resp_ready_o;

    always #5 clk = ~clk;

    dmi_host_master #(
        .MaxRetries    (MaxRetries),
        .RetryGap      (RetryGap),
        .TimeoutCycles (TimeoutCycles)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_ready_o      (cmd_ready_o),
        .cmd_we_i         (cmd_we_i),
        .cmd_addr_i       (cmd_addr_i),
        .cmd_wdata_i      (cmd_wdata_i),
        .clr_i            (clr_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_data_o       (rsp_data_o),
        .rsp_status_o     (rsp_status_o),
        .dmi_rst_no       (dmi_rst_no),
        .dmi_req_o        (dmi_req_o),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_resp_i       (dmi_resp_i),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o)
    );

    typedef struct {
        logic [1:0]  status;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Responder state, configured by the tests
    int          cyc = 0;
    int          req_hs_cnt = 0;
    int          resp_hs_cnt = 0;
    int          req_hs_q[$];
    int          stall_left = 0;
    int          busy_left = 0;
    int          resp_delay = 1;
    int          pend = 0;
    bit          flush = 0;
    logic [1:0]  final_code = 2'd0;
    logic [31:0] final_data = 32'h0;
    logic [40:0] last_req = '0;
    logic        r_req_valid = 0, r_req_ready = 0, r_resp_valid = 0, r_resp_ready = 0;
    logic [40:0] r_req = '0;

    // Responder acts 1 time unit after each edge; tests act 2 after
    initial begin
        dmi_req_ready_i  = 1'b1;
        dmi_resp_valid_i = 1'b0;
        dmi_resp_i       = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (r_resp_valid && r_resp_ready) begin
                dmi_resp_valid_i = 1'b0;
                resp_hs_cnt++;
            end
            if (flush) begin
                pend             = 0;
                dmi_resp_valid_i = 1'b0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        dmi_resp_valid_i = 1'b1;
                        if (busy_left > 0) begin
                            dmi_resp_i = {BusyData, 2'd3};
                            busy_left--;
                        end else begin
                            dmi_resp_i = {final_data, final_code};
                        end
                    end
                end
                if (r_req_valid && r_req_ready) begin
                    req_hs_cnt++;
                    req_hs_q.push_back(cyc);
                    last_req = r_req;
                    pend     = resp_delay;
                end
            end
            if (dmi_req_valid_o && stall_left > 0) begin
                dmi_req_ready_i = 1'b0;
                stall_left--;
            end else begin
                dmi_req_ready_i = 1'b1;
            end
            r_req_valid  = dmi_req_valid_o;
            r_req_ready  = dmi_req_ready_i;
            r_req        = dmi_req_o;
            r_resp_valid = dmi_resp_valid_i;
            r_resp_ready = dmi_resp_ready_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present one command; returns one edge after it was accepted
    task automatic issue(input logic we, input logic [6:0] addr, input logic [31:0] wdata,
                         output bit ok);
        int n;
        n = 0;
        while (!cmd_ready_o && n < 200) begin
            step();
            n++;
        end
        ok          = cmd_ready_o;
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        step();
        cmd_valid_i = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid_o, capture it, optionally consume it
    task automatic wait_rsp(input bit consume, output bit got, output int cycles,
                            output logic [31:0] data, output logic [1:0] status);
        cycles = 0;
        while (!rsp_valid_o && cycles < 400) begin
            step();
            cycles++;
        end
        got    = rsp_valid_o;
        data   = rsp_data_o;
        status = rsp_status_o;
        if (got && consume) begin
            rsp_ready_i = 1'b1;
            step();
            rsp_ready_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) step();
        checks += 8;
        if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready_o); end
        if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o); end
        if (dmi_req_valid_o !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %b expected 0", dmi_req_valid_o); end
        if (dmi_req_o !== 41'h0) begin failures++; $display("FAIL reset_req_payload: got %h expected 0", dmi_req_o); end
        if (dmi_resp_ready_o !== 1'b0) begin failures++; $display("FAIL reset_resp_ready: got %b expected 0", dmi_resp_ready_o); end
        if (rsp_data_o !== 32'h0) begin failures++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data_o); end
        if (rsp_status_o !== 2'd0) begin failures++; $display("FAIL reset_rsp_status: got %0d expected 0", rsp_status_o); end
        if (dmi_rst_no !== 1'b1) begin failures++; $display("FAIL reset_dmi_rst_no: got %b expected 1", dmi_rst_no); end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_read();
        bit ok, got; int cyc_n; logic [31:0] d; logic [1:0] s; exp_t e;
        final_code = 2'd0; final_data = 32'hDEAD_BEEF; resp_delay = 1; busy_left = 0;
        issue(1'b0, 7'h11, 32'h0, ok);
        exp_q.push_back('{2'd0, 32'hDEAD_BEEF});
        wait_rsp(1'b1, got, cyc_n, d, s);
        checks += 4;
        if (!(ok && got)) begin failures++; $display("FAIL read_handshake: got accept=%0d rsp=%0d expected 1 1", ok, got); end
        if (cyc_n + 1 != 4) begin failures++; $display("FAIL read_latency: got %0d expected 4", cyc_n + 1); end
        if (last_req !== {7'h11, 32'h0, 2'd1}) begin failures++; $display("FAIL read_payload: got %h expected %h", last_req, {7'h11, 32'h0, 2'd1}); end
        e = exp_q.pop_front();
        if (s !== e.status || d !== e.data) begin failures++; $display("FAIL read_rsp: got %0d/%h expected %0d/%h", s, d, e.status, e.data); end
    endtask

    task automatic test_write_stall();
        bit ok, got; int cyc_n, hs0; logic [31:0] d; logic [1:0] s; exp_t e; logic [40:0] p;
        p = {7'h04, 32'h1234_5678, 2'd2};
        final_code = 2'd0; final_data = 32'hFFFF_FFFF; stall_left = 3;
        hs0 = req_hs_cnt;
        issue(1'b1, 7'h04, 32'h1234_5678, ok);
        exp_q.push_back('{2'd0, 32'h0});
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dmi_req_valid_o !== 1'b1 || dmi_req_o !== p) begin
                failures++;
                $display("FAIL write_stall_payload[%0d]: got v=%b %h expected v=1 %h", k, dmi_req_valid_o, dmi_req_o, p);
            end
            if (k < 3) step();
        end
        wait_rsp(1'b0, got, cyc_n, d, s);
        step();
        checks += 3;
        if (!(ok && got)) begin failures++; $display("FAIL write_handshake: got accept=%0d rsp=%0d expected 1 1", ok, got); end
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== d || rsp_status_o !== s) begin
            failures++;
            $display("FAIL write_rsp_hold: got v=%b %h/%0d expected v=1 %h/%0d", rsp_valid_o, rsp_data_o, rsp_status_o, d, s);
        end
        if (req_hs_cnt - hs0 != 1) begin failures++; $display("FAIL write_req_count: got %0d expected 1", req_hs_cnt - hs0); end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (s !== e.status || d !== e.data) begin failures++; $display("FAIL write_rsp: got %0d/%h expected %0d/%h", s, d, e.status, e.data); end
    endtask

    task automatic test_retry();
        bit ok, got; int cyc_n, hs0, qb; logic [31:0] d; logic [1:0] s; exp_t e;
        final_code = 2'd0; final_data = 32'hCAFE_0001; busy_left = 2;
        hs0 = req_hs_cnt; qb = req_hs_q.size();
        issue(1'b0, 7'h20, 32'h0, ok);
        exp_q.push_back('{2'd0, 32'hCAFE_0001});
        wait_rsp(1'b1, got, cyc_n, d, s);
        checks += 3;
        if (!(ok && got) || req_hs_cnt - hs0 != 3) begin
            failures++;
            $display("FAIL retry_req_count: got %0d expected 3", req_hs_cnt - hs0);
        end else begin
            if (req_hs_q[qb+1] - req_hs_q[qb] != RetryGap + 3 || req_hs_q[qb+2] - req_hs_q[qb+1] != RetryGap + 3) begin
                failures++;
                $display("FAIL retry_gap: got %0d,%0d expected %0d", req_hs_q[qb+1] - req_hs_q[qb], req_hs_q[qb+2] - req_hs_q[qb+1], RetryGap + 3);
            end
        end
        e = exp_q.pop_front();
        if (s !== e.status || d !== e.data) begin failures++; $display("FAIL retry_rsp: got %0d/%h expected %0d/%h", s, d, e.status, e.data); end
    endtask

    task automatic test_busy_exhaust();
        bit ok, got; int cyc_n, hs0; logic [31:0] d; logic [1:0] s; exp_t e;
        busy_left = 100;
        hs0 = req_hs_cnt;
        issue(1'b0, 7'h16, 32'h0, ok);
        exp_q.push_back('{2'd3, BusyData});
        wait_rsp(1'b1, got, cyc_n, d, s);
        busy_left = 0;
        checks += 2;
        if (!(ok && got) || req_hs_cnt - hs0 != MaxRetries + 1) begin
            failures++;
            $display("FAIL busy_req_count: got %0d expected %0d", req_hs_cnt - hs0, MaxRetries + 1);
        end
        e = exp_q.pop_front();
        if (s !== e.status || d !== e.data) begin failures++; $display("FAIL busy_rsp: got %0d/%h expected %0d/%h", s, d, e.status, e.data); end
    endtask

    task automatic test_failed();
        bit ok, got; int cyc_n; logic [31:0] d; logic [1:0] s; exp_t e;
        final_code = 2'd2; final_data = 32'h0F00_0002;
        issue(1'b0, 7'h38, 32'h0, ok);
        exp_q.push_back('{2'd2, 32'h0F00_0002});
        wait_rsp(1'b1, got, cyc_n, d, s);
        e = exp_q.pop_front();
        checks++;
        if (!got || s !== e.status || d !== e.data) begin failures++; $display("FAIL failed_rsp: got %0d/%h expected %0d/%h", s, d, e.status, e.data); end
        final_code = 2'd1; final_data = 32'h0F00_0001;
        issue(1'b1, 7'h39, 32'h5555_AAAA, ok);
        exp_q.push_back('{2'd2, 32'h0F00_0001});
        wait_rsp(1'b1, got, cyc_n, d, s);
        e = exp_q.pop_front();
        checks++;
        if (!got || s !== e.status || d !== e.data) begin failures++; $display("FAIL reserved_rsp: got %0d/%h expected %0d/%h", s, d, e.status, e.data); end
        final_code = 2'd0;
    endtask

    task automatic test_back_to_back();
        bit ok, got; int cyc_n; logic [31:0] d; logic [1:0] s; exp_t e;
        for (int i = 0; i < 2; i++) begin
            final_data = 32'hA5A5_0000 + 32'(i);
            issue(1'b0, 7'(i + 1), 32'h0, ok);
            exp_q.push_back('{2'd0, 32'hA5A5_0000 + 32'(i)});
            wait_rsp(1'b0, got, cyc_n, d, s);
            checks += 3;
            if (cmd_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_ready_in_done[%0d]: got %b expected 0", i, cmd_ready_o); end
            rsp_ready_i = 1'b1;
            step();
            rsp_ready_i = 1'b0;
            if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle[%0d]: got ready=%b valid=%b expected 1 0", i, cmd_ready_o, rsp_valid_o);
            end
            e = exp_q.pop_front();
            if (!got || s !== e.status || d !== e.data) begin failures++; $display("FAIL b2b_rsp[%0d]: got %0d/%h expected %0d/%h", i, s, d, e.status, e.data); end
        end
    endtask

`ifdef DMI_TIMEOUT_EN
    task automatic test_timeout();
        bit ok, got, seen; int cyc_n, t0, r0; logic [31:0] d; logic [1:0] s; exp_t e;
        final_code = 2'd0; final_data = 32'h0000_1234; resp_delay = 20;
        issue(1'b0, 7'h11, 32'h0, ok);
        t0 = cyc;
        exp_q.push_back('{2'd1, 32'h0});
        wait_rsp(1'b1, got, cyc_n, d, s);
        e = exp_q.pop_front();
        checks += 2;
        if (!got || s !== e.status || d !== e.data) begin failures++; $display("FAIL timeout_rsp: got %0d/%h expected %0d/%h", s, d, e.status, e.data); end
        if (t0 + cyc_n - req_hs_q[$] != TimeoutCycles) begin
            failures++;
            $display("FAIL timeout_cycle: got %0d expected %0d", t0 + cyc_n - req_hs_q[$], TimeoutCycles);
        end
        r0 = resp_hs_cnt; seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid_o) seen = 1;
        end
        checks += 2;
        if (seen) begin failures++; $display("FAIL late_resp_no_rsp: got rsp_valid expected none"); end
        if (resp_hs_cnt - r0 != 1) begin failures++; $display("FAIL late_resp_drained: got %0d expected 1", resp_hs_cnt - r0); end
        resp_delay = 1;
        issue(1'b0, 7'h12, 32'h0, ok);
        exp_q.push_back('{2'd0, 32'h0000_1234});
        wait_rsp(1'b1, got, cyc_n, d, s);
        e = exp_q.pop_front();
        checks++;
        if (!got || s !== e.status || d !== e.data) begin failures++; $display("FAIL after_timeout_rsp: got %0d/%h expected %0d/%h", s, d, e.status, e.data); end
    endtask
`endif

    task automatic test_clr_and_abort();
        bit ok, got, seen; int cyc_n, n; logic [31:0] d; logic [1:0] s; exp_t e;
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        checks += 2;
        if (dmi_rst_no !== 1'b0 || cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL clr_pulse: got rst_no=%b ready=%b expected 0 1", dmi_rst_no, cmd_ready_o);
        end
        step();
        if (dmi_rst_no !== 1'b1) begin failures++; $display("FAIL clr_release: got %b expected 1", dmi_rst_no); end
        clr_i = 1'b1; final_data = 32'h7777_0000;
        issue(1'b0, 7'h05, 32'h0, ok);
        clr_i = 1'b0;
        exp_q.push_back('{2'd0, 32'h7777_0000});
        checks += 2;
        if (dmi_rst_no !== 1'b1 || dmi_req_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL clr_vs_cmd: got rst_no=%b req_valid=%b expected 1 1", dmi_rst_no, dmi_req_valid_o);
        end
        wait_rsp(1'b1, got, cyc_n, d, s);
        e = exp_q.pop_front();
        if (!got || s !== e.status || d !== e.data) begin failures++; $display("FAIL clr_cmd_rsp: got %0d/%h expected %0d/%h", s, d, e.status, e.data); end
        resp_delay = 30;
        issue(1'b0, 7'h06, 32'h0, ok);
        n = 0;
        while (!dmi_resp_ready_o && n < 20) begin step(); n++; end
        checks += 3;
        if (dmi_resp_ready_o !== 1'b1) begin failures++; $display("FAIL abort_reach_wait: got %b expected 1", dmi_resp_ready_o); end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        flush = 1;
        if (cmd_ready_o !== 1'b1 || dmi_req_valid_o !== 1'b0 || dmi_resp_ready_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset_state: got ready=%b reqv=%b respr=%b rspv=%b expected 1 0 0 0",
                     cmd_ready_o, dmi_req_valid_o, dmi_resp_ready_o, rsp_valid_o);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rsp_valid_o) seen = 1;
        end
        if (seen) begin failures++; $display("FAIL abort_no_rsp: got rsp_valid expected none"); end
        flush = 0; resp_delay = 1; final_data = 32'h600D_0001;
        issue(1'b0, 7'h07, 32'h0, ok);
        exp_q.push_back('{2'd0, 32'h600D_0001});
        wait_rsp(1'b1, got, cyc_n, d, s);
        e = exp_q.pop_front();
        checks++;
        if (!got || s !== e.status || d !== e.data) begin failures++; $display("FAIL abort_recover_rsp: got %0d/%h expected %0d/%h", s, d, e.status, e.data); end
    endtask

    initial begin
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0;
        cmd_wdata_i = '0; clr_i = 1'b0; rsp_ready_i = 1'b0;
        #2;
        test_reset();
        test_read();
        test_write_stall();
        test_retry();
        test_busy_exhaust();
        test_failed();
        test_back_to_back();
`ifdef DMI_TIMEOUT_EN
        test_timeout();
`endif
        test_clr_and_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
